// File: rtl/gpio_ir_arbiter.sv
// gpio_ir_arbiter
//
// Round-robin interrupt arbiter/sequencer between the per-port gpio interrupt
// handshakes and a single host interrupt channel. One pending, unmasked port is
// selected at a time, presented to the host, and only cleared in gpio (via its
// ir handshake) after the host signals end-of-interrupt.
//
// Ports:
//   clock       single clock, rising edge
//   reset       asynchronous active-low reset
//   ir_valid    per-port interrupt pending, from gpio
//   ir_ready    per-port interrupt clear pulse, to gpio (one-hot or zero)
//   mask_valid  mask write request
//   mask_ready  mask write accept (always 1)
//   mask        new mask; bit=1 blocks that port from arbitration
//   irq_valid   interrupt presented to host
//   irq_ready   host accepts interrupt
//   irq_id      index of the presented port
//   eoi_valid   host end-of-interrupt
//   eoi_ready   end-of-interrupt accept
//   busy        an interrupt is in flight

module gpio_ir_arbiter #(
    parameter int unsigned PORT_NUM = 8,
    parameter int unsigned ID_WIDTH = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PORT_NUM-1:0] ir_valid,
    output logic [PORT_NUM-1:0] ir_ready,
    input  logic                mask_valid,
    output logic                mask_ready,
    input  logic [PORT_NUM-1:0] mask,
    output logic                irq_valid,
    input  logic                irq_ready,
    output logic [ID_WIDTH-1:0] irq_id,
    input  logic                eoi_valid,
    output logic                eoi_ready,
    output logic                busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StService, StClear} state_e;

    localparam logic [ID_WIDTH-1:0] LastId   = ID_WIDTH'(PORT_NUM - 1);
    localparam logic [ID_WIDTH:0]   PortNumW = (ID_WIDTH + 1)'(PORT_NUM);

    state_e                state_q, state_d;
    logic [ID_WIDTH-1:0]   sel_q, sel_d;
    logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
    logic [PORT_NUM-1:0]   mask_q, mask_d;

    logic [PORT_NUM-1:0]   eligible;
    logic                  found;
    logic [ID_WIDTH-1:0]   pick;
    logic [ID_WIDTH:0]     idx;

    // Round-robin search: first eligible port at or above ptr_q, wrapping at
    // PORT_NUM. ptr_q < PORT_NUM always holds, so one subtraction suffices.
    always_comb begin
        eligible = ir_valid & ~mask_q;
        found    = 1'b0;
        pick     = '0;
        idx      = '0;
        for (int i = 0; i < int'(PORT_NUM); i++) begin
            idx = {1'b0, ptr_q} + (ID_WIDTH + 1)'(i);
            if (idx >= PortNumW) begin
                idx = idx - PortNumW;
            end
            if (!found && eligible[idx[ID_WIDTH-1:0]]) begin
                found = 1'b1;
                pick  = idx[ID_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        mask_d    = mask_valid ? mask : mask_q;
        irq_valid = 1'b0;
        eoi_ready = 1'b0;
        ir_ready  = '0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    sel_d   = pick;
                    state_d = StIssue;
                end
            end
            // Request is committed: mask writes or ir_valid drops do not withdraw it.
            StIssue: begin
                irq_valid = 1'b1;
                if (irq_ready) begin
                    state_d = StService;
                end
            end
            StService: begin
                eoi_ready = 1'b1;
                if (eoi_valid) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                ir_ready[sel_q] = 1'b1;
                ptr_d           = (sel_q == LastId) ? '0 : sel_q + 1'b1;
                state_d         = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign irq_id     = irq_valid ? sel_q : '0;
    assign busy       = (state_q != StIdle);
    assign mask_ready = 1'b1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            sel_q   <= '0;
            ptr_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            mask_q  <= mask_d;
        end
    end

endmodule

// File: tb/tb_gpio_ir_arbiter.sv
// Testbench for gpio_ir_arbiter: an 8-port and a 6-port instance run side by
// side against a transaction-phase reference model, with directed scenarios
// followed by randomized traffic.

module tb_gpio_ir_arbiter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic [7:0] ir_valid0;
    logic [5:0] ir_valid1;
    logic       mask_valid;
    logic [7:0] mask;
    logic       irq_ready;
    logic       eoi_valid;

    logic [7:0] ir_ready0;
    logic [5:0] ir_ready1;
    logic       mask_ready0, mask_ready1;
    logic       irq_valid0, irq_valid1;
    logic [2:0] irq_id0, irq_id1;
    logic       eoi_ready0, eoi_ready1;
    logic       busy0, busy1;

    gpio_ir_arbiter #(.PORT_NUM(8), .ID_WIDTH(3)) dut0 (
        .clock      (clock),
        .reset      (reset),
        .ir_valid   (ir_valid0),
        .ir_ready   (ir_ready0),
        .mask_valid (mask_valid),
        .mask_ready (mask_ready0),
        .mask       (mask),
        .irq_valid  (irq_valid0),
        .irq_ready  (irq_ready),
        .irq_id     (irq_id0),
        .eoi_valid  (eoi_valid),
        .eoi_ready  (eoi_ready0),
        .busy       (busy0)
    );

    gpio_ir_arbiter #(.PORT_NUM(6), .ID_WIDTH(3)) dut1 (
        .clock      (clock),
        .reset      (reset),
        .ir_valid   (ir_valid1),
        .ir_ready   (ir_ready1),
        .mask_valid (mask_valid),
        .mask_ready (mask_ready1),
        .mask       (mask[5:0]),
        .irq_valid  (irq_valid1),
        .irq_ready  (irq_ready),
        .irq_id     (irq_id1),
        .eoi_valid  (eoi_valid),
        .eoi_ready  (eoi_ready1),
        .busy       (busy1)
    );

    int tests = 0;
    int fails = 0;

    // Model: phase 0 waiting, 1 presented, 2 host servicing, 3 clearing gpio.
    int         m_phase [2];
    int         m_sel   [2];
    int         m_ptr   [2];
    logic [7:0] m_mask  [2];

    logic [7:0] pend0;
    logic [5:0] pend1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int port_cnt(input int u);
        return (u == 0) ? 8 : 6;
    endfunction

    // Rotate the eligible set so ptr lands at bit 0, isolate the lowest set bit,
    // then rotate the position back.
    function automatic int rr_pick(input logic [7:0] e, input int p, input int n);
        logic [15:0] w, rot, low;
        int b;
        w   = {8'b0, e};
        rot = ((w >> p) | (w << (n - p))) & ((16'd1 << n) - 16'd1);
        low = rot & (~rot + 16'd1);
        b   = $clog2(low);
        return (b + p) % n;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_phase[u] = 0;
            m_sel[u]   = 0;
            m_ptr[u]   = 0;
            m_mask[u]  = 8'h00;
        end
    endtask

    task automatic model_step(input int u, input logic [7:0] iv);
        logic [7:0] nm, e;
        int n;
        n  = port_cnt(u);
        nm = (u == 0) ? 8'hFF : 8'h3F;
        e  = iv & ~m_mask[u] & nm;
        case (m_phase[u])
            0: if (e != 0) begin
                m_sel[u]   = rr_pick(e, m_ptr[u], n);
                m_phase[u] = 1;
            end
            1: if (irq_ready) m_phase[u] = 2;
            2: if (eoi_valid) m_phase[u] = 3;
            default: begin
                m_ptr[u]   = (m_sel[u] + 1) % n;
                m_phase[u] = 0;
            end
        endcase
        if (mask_valid) m_mask[u] = mask & nm;
    endtask

    task automatic check_inst(input int u, input logic [7:0] irr, input logic iv,
                              input logic [2:0] id, input logic er, input logic bz,
                              input logic mr);
        string p;
        p = (u == 0) ? "p8" : "p6";
        check_eq({p, ".irq_valid"}, iv, m_phase[u] == 1);
        if (m_phase[u] == 1) check_eq({p, ".irq_id"}, id, m_sel[u]);
        check_eq({p, ".ir_ready"}, irr, (m_phase[u] == 3) ? (32'd1 << m_sel[u]) : 32'd0);
        check_eq({p, ".eoi_ready"}, er, m_phase[u] == 2);
        check_eq({p, ".busy"}, bz, m_phase[u] != 0);
        check_eq({p, ".mask_ready"}, mr, 1);
    endtask

    task automatic check_outputs();
        check_inst(0, ir_ready0, irq_valid0, irq_id0, eoi_ready0, busy0, mask_ready0);
        check_inst(1, {2'b0, ir_ready1}, irq_valid1, irq_id1, eoi_ready1, busy1, mask_ready1);
    endtask

    // Called just after a falling edge; leaves the time just after the next one.
    task automatic cycle(input logic [7:0] iv0, input logic [5:0] iv1, input logic mv,
                         input logic [7:0] mk, input logic ir, input logic eo);
        ir_valid0  = iv0;
        ir_valid1  = iv1;
        mask_valid = mv;
        mask       = mk;
        irq_ready  = ir;
        eoi_valid  = eo;
        model_step(0, iv0);
        model_step(1, {2'b0, iv1});
        @(posedge clock);
        @(negedge clock);
        check_outputs();
    endtask

    // Asserts reset mid-cycle and checks the outputs drop before any clock edge.
    task automatic do_reset(input logic eo);
        eoi_valid  = eo;
        irq_ready  = 1'b0;
        mask_valid = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs();
        check_eq("rst.irq_id", irq_id0, 0);
        check_eq("rst.ir_ready", ir_ready0, 0);
        @(posedge clock);
        #1;
        check_eq("rst.hold_ir_ready", ir_ready0, 0);
        check_eq("rst.hold_busy", busy0, 0);
        @(negedge clock);
        reset     = 1'b1;
        eoi_valid = 1'b0;
        check_outputs();
    endtask

    initial begin
        reset      = 1'b1;
        ir_valid0  = '0;
        ir_valid1  = '0;
        mask_valid = 1'b0;
        mask       = '0;
        irq_ready  = 1'b0;
        eoi_valid  = 1'b0;
        pend0      = '0;
        pend1      = '0;
        model_reset();
        @(negedge clock);
        do_reset(1'b0);

        // Ports 5 and 2 pending from ptr 0: 2 first, then 5, then ptr lands on 6.
        cycle(8'h24, 6'h00, 0, 8'h00, 0, 0);
        check_eq("s1.first_id", irq_id0, 2);
        cycle(8'h24, 6'h00, 0, 8'h00, 1, 0);
        cycle(8'h24, 6'h00, 0, 8'h00, 0, 1);
        check_eq("s1.clear2", ir_ready0, 8'h04);
        cycle(8'h20, 6'h00, 0, 8'h00, 0, 0);
        check_eq("s1.clear_once", ir_ready0, 8'h00);
        cycle(8'h20, 6'h00, 0, 8'h00, 0, 0);
        check_eq("s1.second_id", irq_id0, 5);
        cycle(8'h20, 6'h00, 0, 8'h00, 1, 0);
        cycle(8'h20, 6'h00, 0, 8'h00, 0, 1);
        check_eq("s1.clear5", ir_ready0, 8'h20);
        cycle(8'h00, 6'h00, 0, 8'h00, 0, 0);
        cycle(8'hFF, 6'h00, 0, 8'h00, 0, 0);
        check_eq("s1.ptr_after5", irq_id0, 6);

        // All ports pending, serviced back to back: strict rotation, 4 cycles apart.
        for (int k = 1; k <= 10; k++) begin
            repeat (4) cycle(8'hFF, 6'h00, 0, 8'h00, 1, 1);
            check_eq("s2.rotate", irq_id0, (6 + k) % 8);
        end

        // Mask written on the same cycle as arbitration: old mask applies.
        do_reset(1'b0);
        cycle(8'h03, 6'h00, 1, 8'h01, 0, 0);
        check_eq("s3.old_mask_id", irq_id0, 0);
        cycle(8'h03, 6'h00, 0, 8'h00, 1, 0);
        cycle(8'h03, 6'h00, 0, 8'h00, 0, 1);
        check_eq("s3.clear0", ir_ready0, 8'h01);
        cycle(8'h03, 6'h00, 0, 8'h00, 0, 0);
        cycle(8'h03, 6'h00, 0, 8'h00, 0, 0);
        check_eq("s3.masked_id", irq_id0, 1);
        cycle(8'h03, 6'h00, 0, 8'h00, 1, 0);
        cycle(8'h03, 6'h00, 0, 8'h00, 0, 1);
        for (int k = 0; k < 6; k++) begin
            cycle(8'h01, 6'h00, 0, 8'h00, 0, 0);
            check_eq("s3.port0_blocked", irq_valid0, 0);
        end
        cycle(8'h01, 6'h00, 1, 8'h00, 0, 0);
        check_eq("s3.unmask_latency", irq_valid0, 0);
        cycle(8'h01, 6'h00, 0, 8'h00, 0, 0);
        check_eq("s3.unmasked_valid", irq_valid0, 1);
        check_eq("s3.unmasked_id", irq_id0, 0);

        // Stall in ISSUE with sel masked and ir_valid toggling; EOI pulses ignored.
        for (int k = 0; k < 10; k++) begin
            cycle((k % 2 == 1) ? 8'h01 : 8'h00, 6'h00, k == 0, 8'h01, 0, k % 2 == 1);
            check_eq("s4.valid", irq_valid0, 1);
            check_eq("s4.id", irq_id0, 0);
            check_eq("s4.eoi_ready", eoi_ready0, 0);
            check_eq("s4.ir_ready", ir_ready0, 0);
        end

        // 6-port wrap: port 5 serviced -> ptr 0; pending {0,4} picks 0.
        do_reset(1'b0);
        cycle(8'h00, 6'h20, 0, 8'h00, 0, 0);
        check_eq("s5.id5", irq_id1, 5);
        cycle(8'h00, 6'h20, 0, 8'h00, 1, 0);
        cycle(8'h00, 6'h20, 0, 8'h00, 0, 1);
        check_eq("s5.clear5", ir_ready1, 6'h20);
        cycle(8'h00, 6'h11, 0, 8'h00, 0, 0);
        cycle(8'h00, 6'h11, 0, 8'h00, 0, 0);
        check_eq("s5.wrap_id", irq_id1, 0);

        // Reset while in SERVICE abandons the interrupt; port 3 is reissued.
        do_reset(1'b0);
        cycle(8'h08, 6'h00, 0, 8'h00, 0, 0);
        cycle(8'h08, 6'h00, 0, 8'h00, 1, 0);
        check_eq("s6.in_service", eoi_ready0, 1);
        ir_valid0 = 8'h08;
        do_reset(1'b1);
        cycle(8'h08, 6'h00, 0, 8'h00, 0, 0);
        check_eq("s6.reissue_id", irq_id0, 3);

        // Randomized traffic with a simple gpio model that drops a serviced line.
        do_reset(1'b0);
        for (int it = 0; it < 3000; it++) begin
            logic       mv;
            logic [7:0] mk;
            if ($urandom_range(0, 399) == 0) do_reset(1'b0);
            if (m_phase[0] == 3) pend0[m_sel[0]] = 1'b0;
            if (m_phase[1] == 3) pend1[m_sel[1]] = 1'b0;
            pend0 = pend0 | 8'($urandom & $urandom & $urandom);
            pend1 = pend1 | 6'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 31) == 0) pend0 = pend0 & 8'($urandom);
            if ($urandom_range(0, 31) == 0) pend1 = pend1 & 6'($urandom);
            mv = ($urandom_range(0, 15) == 0);
            mk = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom & $urandom);
            cycle(pend0, pend1, mv, mk, $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
